// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_SRC packet sources.
// Whole-packet grants with optional source-ID header, payload length cap and stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned HEADER_EN     = 1,
    parameter logic [7:0]  HEADER_BASE   = 8'hA0,
    parameter int unsigned MAX_PKT_LEN   = 64,
    parameter int unsigned STALL_TIMEOUT = 65535
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_SRC-1:0]       src_valid_in,
    input  logic [8*NUM_SRC-1:0]     src_data_in,
    input  logic [NUM_SRC-1:0]       src_last_in,
    output logic [NUM_SRC-1:0]       src_ready_out,
    output logic                     tx_valid_out,
    output logic [7:0]               tx_byte_out,
    input  logic                     tx_ready_in,
    output logic [2:0]               grant_id_out,
    output logic                     busy_out,
    output logic                     abort_out
);

    localparam int unsigned GRANT_W = 3;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   MAX_LEN     = CNT_W'(MAX_PKT_LEN);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_SAT   = '1;

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("uart_tx_arbiter: NUM_SRC must be 2..8");
    end
    if (HEADER_BASE[2:0] != 3'd0) begin : g_bad_header_base
        $error("uart_tx_arbiter: HEADER_BASE low 3 bits must be zero");
    end
    if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > 255) begin : g_bad_max_len
        $error("uart_tx_arbiter: MAX_PKT_LEN must be 1..255");
    end
    if (STALL_TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: STALL_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     byte_count_q, byte_count_d;
    logic [STALL_W-1:0]   stall_count_q, stall_count_d;
    logic                 abort_q, abort_d;

    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_byte;
    logic                 xfer;
    logic                 pick_found;
    logic [GRANT_W-1:0]   pick_idx;
    logic [IDX_W-1:0]     cand;
    logic [CNT_W-1:0]     cnt_inc;
    logic [STALL_W-1:0]   stall_inc;

    // Select the granted source's valid/last/byte lanes
    always_comb begin : src_mux
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = 8'd0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_valid = src_valid_in[i];
                sel_last  = src_last_in[i];
                sel_byte  = src_data_in[8*i +: 8];
            end
        end
    end

    // Scan from last_grant+1 with wrap; iterating farthest-first lets the nearest valid source win
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = int'(NUM_SRC); k >= 1; k--) begin
            cand = IDX_W'(last_grant_q) + IDX_W'(k);
            if (cand >= IDX_W'(NUM_SRC)) begin
                cand = cand - IDX_W'(NUM_SRC);
            end
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (cand == IDX_W'(i) && src_valid_in[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand[GRANT_W-1:0];
                end
            end
        end
    end

    assign xfer      = sel_valid & tx_ready_in;
    assign cnt_inc   = byte_count_q + CNT_W'(1);
    assign stall_inc = (stall_count_q == STALL_SAT) ? stall_count_q
                                                    : stall_count_q + STALL_W'(1);

    // State register and datapath flops
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= GRANT_W'(NUM_SRC - 1);
            byte_count_q  <= '0;
            stall_count_q <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            byte_count_q  <= byte_count_d;
            stall_count_q <= stall_count_d;
            abort_q       <= abort_d;
        end
    end

    // Next-state and counter update
    always_comb begin : next_state
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        byte_count_d  = byte_count_q;
        stall_count_d = stall_count_q;
        abort_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d       = pick_idx;
                    last_grant_d  = pick_idx;
                    byte_count_d  = '0;
                    stall_count_d = '0;
                    state_d       = (HEADER_EN != 0) ? S_HEADER : S_PAYLOAD;
                end
            end
            S_HEADER: begin
                if (tx_ready_in) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    byte_count_d  = cnt_inc;
                    stall_count_d = '0;
                    // last wins over the length cap when both land on the same byte
                    if (sel_last) begin
                        state_d = S_IDLE;
                    end else if (cnt_inc == MAX_LEN) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end
                end else begin
                    stall_count_d = stall_inc;
                    if (stall_inc == STALL_LIMIT) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Channel outputs: header byte, or combinational pass-through of the granted source
    always_comb begin : outputs
        tx_valid_out  = 1'b0;
        tx_byte_out   = 8'd0;
        src_ready_out = '0;
        case (state_q)
            S_HEADER: begin
                tx_valid_out = 1'b1;
                tx_byte_out  = HEADER_BASE | 8'(grant_q);
            end
            S_PAYLOAD: begin
                tx_valid_out = sel_valid;
                tx_byte_out  = sel_byte;
                for (int i = 0; i < int'(NUM_SRC); i++) begin
                    if (grant_q == GRANT_W'(i)) begin
                        src_ready_out[i] = tx_ready_in;
                    end
                end
            end
            default: begin
                tx_valid_out = 1'b0;
            end
        endcase
    end

    assign busy_out     = (state_q != S_IDLE);
    assign grant_id_out = grant_q;
    assign abort_out    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues drive the sources and an
// expected-byte queue is compared against every byte accepted by the uart side.
module tb_uart_tx_arbiter;

    localparam int unsigned NSRC   = 4;
    localparam int unsigned MAXLEN = 64;
    localparam int unsigned STALL  = 20;

    logic                clk_in;
    logic                rst_n_in;
    logic [NSRC-1:0]     src_valid_in;
    logic [8*NSRC-1:0]   src_data_in;
    logic [NSRC-1:0]     src_last_in;
    logic [NSRC-1:0]     src_ready_out;
    logic                tx_valid_out;
    logic [7:0]          tx_byte_out;
    logic                tx_ready_in;
    logic [2:0]          grant_id_out;
    logic                busy_out;
    logic                abort_out;

    uart_tx_arbiter #(
        .NUM_SRC      (NSRC),
        .HEADER_EN    (1),
        .HEADER_BASE  (8'hA0),
        .MAX_PKT_LEN  (MAXLEN),
        .STALL_TIMEOUT(STALL)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .src_valid_in (src_valid_in),
        .src_data_in  (src_data_in),
        .src_last_in  (src_last_in),
        .src_ready_out(src_ready_out),
        .tx_valid_out (tx_valid_out),
        .tx_byte_out  (tx_byte_out),
        .tx_ready_in  (tx_ready_in),
        .grant_id_out (grant_id_out),
        .busy_out     (busy_out),
        .abort_out    (abort_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] sq [NSRC][$];
    logic [7:0] exp_q [$];
    logic [NSRC-1:0] src_take = '0;
    int take_cnt [NSRC] = '{default: 0};
    int abort_cnt = 0;
    int abort_gap = -1;
    int last_xfer_edge = 0;
    bit ready_mode = 1'b0;
    int rcnt = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input int s, input int n, input int base, input bit end_last);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = 8'(base + k);
            sq[s].push_back({end_last && (k == n - 1), d});
            exp_q.push_back(d);
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid_out), 32'd0);
        check({tag, "_tx_byte"},  32'(tx_byte_out),  32'd0);
        check({tag, "_src_rdy"},  32'(src_ready_out), 32'd0);
        check({tag, "_grant"},    32'(grant_id_out), 32'd0);
        check({tag, "_busy"},     32'(busy_out),     32'd0);
        check({tag, "_abort"},    32'(abort_out),    32'd0);
    endtask

    // Source and uart-ready driver: pops accepted bytes and presents queue heads after each edge
    initial begin
        src_valid_in = '0;
        src_data_in  = '0;
        src_last_in  = '0;
        tx_ready_in  = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            for (int i = 0; i < int'(NSRC); i++) begin
                if (src_take[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            end
            for (int i = 0; i < int'(NSRC); i++) begin
                if (sq[i].size() > 0) begin
                    src_valid_in[i]        = 1'b1;
                    src_data_in[8*i +: 8]  = sq[i][0][7:0];
                    src_last_in[i]         = sq[i][0][8];
                end else begin
                    src_valid_in[i]        = 1'b0;
                    src_data_in[8*i +: 8]  = 8'd0;
                    src_last_in[i]         = 1'b0;
                end
            end
            if (ready_mode) begin
                tx_ready_in = (rcnt == 0);
                rcnt = (rcnt == 10) ? 0 : rcnt + 1;
            end else begin
                tx_ready_in = 1'b1;
            end
        end
    end

    // Mid-cycle monitor: what is valid&ready here transfers on the next rising edge
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                prev_hold = 1'b0;
                src_take  = '0;
            end else begin
                if (abort_out) begin
                    abort_cnt++;
                    abort_gap = cyc - last_xfer_edge;
                end
                if (prev_hold) begin
                    check("hold_valid", 32'(tx_valid_out), 32'd1);
                    check("hold_byte", 32'(tx_byte_out), 32'(prev_byte));
                end
                check("one_ready", 32'($countones(src_ready_out) > 1), 32'd0);
                src_take = src_valid_in & src_ready_out;
                for (int i = 0; i < int'(NSRC); i++) begin
                    if (src_take[i]) begin
                        take_cnt[i]++;
                        check("src_to_tx", 32'({tx_valid_out, tx_ready_in, tx_byte_out}),
                              32'({2'b11, src_data_in[8*i +: 8]}));
                    end
                end
                if (tx_valid_out && tx_ready_in) begin
                    last_xfer_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(tx_byte_out), 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(tx_byte_out), 32'(e));
                    end
                end
                prev_hold = tx_valid_out && !tx_ready_in;
                prev_byte = tx_byte_out;
            end
        end
    end

    initial begin
        int a0;
        int t0;
        int n;
        int rr_src [3] = '{0, 1, 3};

        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("por");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;

        // Lone source 2, three-byte packet
        a0 = abort_cnt;
        push_exp(8'hA2);
        sq[2].push_back({1'b0, 8'h11}); push_exp(8'h11);
        sq[2].push_back({1'b0, 8'h22}); push_exp(8'h22);
        sq[2].push_back({1'b1, 8'h33}); push_exp(8'h33);
        wait_drain(40, "single");
        check("single_busy_after", 32'(busy_out), 32'd0);
        check("single_grant", 32'(grant_id_out), 32'd2);
        check("single_no_abort", 32'(abort_cnt - a0), 32'd0);

        // Reset asserted mid-payload, observed before any clock edge
        push_exp(8'hA0);
        push_pkt(0, 10, 8'h30, 1'b1);
        n = 0;
        while (exp_q.size() > 7 && n < 50) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        check("midrst_progress", 32'(exp_q.size() <= 7), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sq[0].delete();
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #2;

        // Sources 0,1,3 contend with two packets each: strict rotation starting at source 0
        a0 = abort_cnt;
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 3; j++) begin
                push_exp(8'(32'hA0 | rr_src[j]));
                push_pkt(rr_src[j], 2, 16 * rr_src[j] + 8 * rep + 1, 1'b1);
            end
        end
        wait_drain(120, "rr");
        check("rr_no_abort", 32'(abort_cnt - a0), 32'd0);
        check("rr_grant_last", 32'(grant_id_out), 32'd3);

        // uart ready high one cycle in eleven
        t0 = take_cnt[2];
        rcnt = 0;
        ready_mode = 1'b1;
        push_exp(8'hA2);
        push_pkt(2, 4, 8'hC5, 1'b1);
        wait_drain(200, "slow");
        ready_mode = 1'b0;
        check("slow_src_pulses", 32'(take_cnt[2] - t0), 32'd4);
        @(posedge clk_in);
        #2;

        // 70-byte packet from source 1 truncated at 64, remainder re-granted
        a0 = abort_cnt;
        push_exp(8'hA1);
        push_pkt(1, 64, 8'h40, 1'b0);
        push_exp(8'hA1);
        push_pkt(1, 6, 8'h80, 1'b1);
        wait_drain(300, "maxlen");
        check("maxlen_abort_cnt", 32'(abort_cnt - a0), 32'd1);
        check("maxlen_abort_gap", 32'(abort_gap), 32'd0);
        check("maxlen_grant", 32'(grant_id_out), 32'd1);

        // Source 0 stalls after one byte; source 3 waits behind it
        a0 = abort_cnt;
        push_exp(8'hA0);
        push_pkt(0, 1, 8'h5A, 1'b0);
        push_exp(8'hA3);
        push_exp(8'h61);
        push_exp(8'h62);
        n = 0;
        while (!(busy_out && grant_id_out == 3'd0) && n < 20) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        check("stall_grant0", 32'({busy_out, grant_id_out}), 32'({1'b1, 3'd0}));
        sq[3].push_back({1'b0, 8'h61});
        sq[3].push_back({1'b1, 8'h62});
        wait_drain(100, "stall");
        check("stall_abort_cnt", 32'(abort_cnt - a0), 32'd1);
        check("stall_abort_gap", 32'(abort_gap), 32'(STALL));
        check("stall_grant3", 32'(grant_id_out), 32'd3);
        repeat (3) @(posedge clk_in);
        #2;
        check("end_idle", 32'(busy_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx byte channel between NUM_SRC packet sources. It grants the channel to one source for a whole packet and optionally prefixes each packet with a source-ID header byte. It also enforces a maximum packet length and a stall timeout, so a misbehaving source cannot hold the UART.
It sits between the debug/telemetry producers and uart_tx: tx_valid_out/tx_byte_out drive uart_tx valid_in/byte_in, and tx_ready_in comes from uart_tx ready_out.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
HEADER_EN, 1, 1 = send header byte before each packet; 0 = no header
HEADER_BASE, 8'hA0, header byte = HEADER_BASE | source index (low 3 bits of HEADER_BASE must be 0)
MAX_PKT_LEN, 64, maximum payload bytes per grant (1..255)
STALL_TIMEOUT, 65535, idle cycles allowed mid-packet before abort

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
src_valid_in  input  NUM_SRC  per-source byte valid
src_data_in  input  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i]
src_last_in  input  NUM_SRC  per-source last byte of packet, qualified by valid
src_ready_out  output  NUM_SRC  per-source byte accepted when valid & ready
tx_valid_out  output  1  byte valid to uart_tx
tx_byte_out  output  8  byte to uart_tx
tx_ready_in  input  1  uart_tx ready
grant_id_out  output  3  current or last granted source index
busy_out  output  1  high in any state other than IDLE
abort_out  output  1  one-cycle pulse when a packet is truncated or timed out

Behaviour:
- Reset (rst_n_in low, asynchronous): state = IDLE; tx_valid_out = 0; tx_byte_out = 0; src_ready_out = 0; grant_id_out = 0; busy_out = 0; abort_out = 0; last_grant = NUM_SRC-1, so source 0 has top priority first; counters = 0.
- A byte transfers on a rising edge where valid and ready are both high, on either interface.
- States:
  - IDLE
    - If any src_valid_in is high, pick the first valid source scanning from last_grant+1 with wrap.
    - Register grant_id_out and last_grant, then go to HEADER if HEADER_EN, else PAYLOAD.
    - Arbitration costs 1 cycle. No source has ready in IDLE.
  - HEADER
    - tx_valid_out = 1; tx_byte_out = HEADER_BASE | grant.
    - On tx_ready_in, go to PAYLOAD.
    - Header bytes are not counted toward MAX_PKT_LEN.
  - PAYLOAD
    - Combinational pass-through: tx_valid_out = src_valid_in[grant]; tx_byte_out = src byte[grant]; src_ready_out[grant] = tx_ready_in. All other ready bits are 0.
    - On each transfer, byte_count increments and stall_count clears.
    - A transfer with last = 1 goes to IDLE.
    - A transfer where byte_count reaches MAX_PKT_LEN without last pulses abort_out and goes to IDLE. The source's remaining bytes form a new packet on a later grant.
  - Stall counting (PAYLOAD only)
    - stall_count increments on every cycle without a transfer.
    - On reaching STALL_TIMEOUT: pulse abort_out, go to IDLE, and emit nothing further for that packet.
- Back-to-back packets:
  - A source that finishes is lowest priority at the next arbitration.
  - A lone requester is re-granted after one IDLE cycle.
- tx_ready_in dropping while tx_valid_out is high is legal. tx_byte_out must stay stable until the transfer.
- Source valid dropping mid-packet is legal; only the stall timer applies.
- Width rules:
  - byte_count is 8 bits and is compared with ==. It never wraps because it is capped at MAX_PKT_LEN.
  - stall_count is $clog2(STALL_TIMEOUT+1) bits and saturates.
- Reset asserted mid-packet: the arbiter returns immediately to its reset state. The partially sent packet is not completed; the downstream parser resynchronises on the next header.
- Simultaneous last and MAX_PKT_LEN on the same byte: treated as a normal end of packet, no abort_out.

Test Plan:
- Source 2 only, HEADER_EN = 1, sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) -> uart sees 0xA2, 0x11, 0x22, 0x33; grant_id_out = 2; busy_out low 1 cycle after the 0x33 transfer; abort_out never pulses.
- Sources 0, 1, 3 all request 2-byte packets continuously -> header order 0xA0, 0xA1, 0xA3, 0xA0, …; no source granted twice in a row while others wait.
- tx_ready_in emulates uart_tx (high 1 cycle, then low 10 cycles) -> each byte is held stable while ready is low; no bytes duplicated or lost; src_ready_out[i] pulses exactly once per byte.
- Source 1 sends 70 bytes without last, MAX_PKT_LEN = 64 -> 64 payload bytes, then abort_out pulses; next grant to source 1 (others idle) sends 0xA1 followed by the remaining 6 bytes.
- STALL_TIMEOUT = 20; source 0 sends 1 byte then drops valid -> abort_out pulses 20 cycles after the last transfer; arbiter returns to IDLE and serves pending source 3.
- rst_n_in pulsed low mid-payload -> all outputs at reset values immediately, without waiting for a clock edge; after release, source 0 is granted first.
